// File: rtl/tri_pkg.sv
// Shared types and widths for the triangle rasterizer host: coordinate and grid sizes,
// the host state encoding, and the vertex payload.
package tri_pkg;
  localparam int unsigned COORD_W = 3;
  localparam int unsigned GRID    = 8;
  localparam int unsigned PIX_W   = 7;
  localparam int unsigned NPIX    = GRID * GRID;
  localparam int unsigned IDX_W   = 2 * COORD_W;
  localparam int unsigned TIMER_W = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    V1        = 3'd1,
    V2        = 3'd2,
    V3        = 3'd3,
    WAIT_BUSY = 3'd4,
    RUN       = 3'd5,
    DONE      = 3'd6
  } state_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } vertex_t;
endpackage

// File: rtl/tri_bitmap.sv
// 8x8 point accumulator: set/clear, duplicate detection, distinct-point count and
// registered row readback that returns the bitmap as it stood before any same-cycle set.
module tri_bitmap
  import tri_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               set_en,
  input  logic [COORD_W-1:0] set_x,
  input  logic [COORD_W-1:0] set_y,
  input  logic               rd_en,
  input  logic [COORD_W-1:0] rd_row,
  output logic [PIX_W-1:0]   pix_count,
  output logic               dup_seen,
  output logic [GRID-1:0]    rd_data,
  output logic               rd_valid
);
  logic [NPIX-1:0]  bits_q;
  logic [IDX_W-1:0] idx_c;
  logic [IDX_W-1:0] row_base_c;
  logic             hit_c;

  assign idx_c      = {set_y, set_x};
  assign row_base_c = {rd_row, COORD_W'(0)};
  assign hit_c      = bits_q[idx_c];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bits_q    <= '0;
      pix_count <= '0;
      dup_seen  <= 1'b0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= bits_q[row_base_c +: GRID];
      if (clr) begin
        bits_q    <= '0;
        pix_count <= '0;
        dup_seen  <= 1'b0;
      end else if (set_en) begin
        if (hit_c) begin
          dup_seen <= 1'b1;
        end else begin
          bits_q[idx_c] <= 1'b1;
          pix_count     <= pix_count + PIX_W'(1);
        end
      end
    end
  end
endmodule

// File: rtl/tri_host.sv
// Host-side driver for the 8x8 triangle rasterizer: takes one descriptor, loads the
// three vertices, supervises busy with timeouts and collects emitted points.
module tri_host
  import tri_pkg::*;
#(
  parameter int unsigned START_TIMEOUT = 4,
  parameter int unsigned RUN_TIMEOUT   = 200
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [COORD_W-1:0] cmd_x1,
  input  logic [COORD_W-1:0] cmd_y1,
  input  logic [COORD_W-1:0] cmd_x2,
  input  logic [COORD_W-1:0] cmd_y2,
  input  logic [COORD_W-1:0] cmd_x3,
  input  logic [COORD_W-1:0] cmd_y3,
  output logic               nt,
  output logic [COORD_W-1:0] xi,
  output logic [COORD_W-1:0] yi,
  input  logic               busy,
  input  logic               po,
  input  logic [COORD_W-1:0] xo,
  input  logic [COORD_W-1:0] yo,
  output logic               done,
  output logic               err_timeout,
  output logic [PIX_W-1:0]   pix_count,
  output logic               dup_seen,
  input  logic               rd_en,
  input  logic [COORD_W-1:0] rd_row,
  output logic [GRID-1:0]    rd_data,
  output logic               rd_valid
);
  state_t             state, state_d;
  logic [TIMER_W-1:0] timer, timer_d;
  vertex_t            v2_q, v3_q;
  logic               accept_c;
  logic               nt_d, done_d, err_d, cmd_ready_d;
  logic [COORD_W-1:0] xi_d, yi_d;

  // State, timer, vertex latch and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      timer       <= '0;
      v2_q        <= '0;
      v3_q        <= '0;
      cmd_ready   <= 1'b0;
      nt          <= 1'b0;
      xi          <= '0;
      yi          <= '0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_d;
      timer       <= timer_d;
      cmd_ready   <= cmd_ready_d;
      nt          <= nt_d;
      xi          <= xi_d;
      yi          <= yi_d;
      done        <= done_d;
      err_timeout <= err_d;
      if (accept_c) begin
        v2_q <= '{x: cmd_x2, y: cmd_y2};
        v3_q <= '{x: cmd_x3, y: cmd_y3};
      end
    end
  end

  // Next state; outputs are decoded from the next state so they align with it.
  // Vertex 1 goes straight from the command inputs into xi/yi on the accept edge.
  always_comb begin
    state_d  = state;
    accept_c = 1'b0;
    err_d    = err_timeout;
    nt_d     = 1'b0;
    done_d   = 1'b0;
    xi_d     = '0;
    yi_d     = '0;
    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready && !busy) begin
          accept_c = 1'b1;
          err_d    = 1'b0;
          state_d  = V1;
        end
      end
      V1: state_d = V2;
      V2: state_d = V3;
      V3: state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        if (busy) begin
          state_d = RUN;
        end else if (timer == TIMER_W'(START_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      RUN: begin
        if (!busy) begin
          state_d = DONE;
        end else if (timer == TIMER_W'(RUN_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    case (state_d)
      V1: begin
        nt_d = 1'b1;
        xi_d = cmd_x1;
        yi_d = cmd_y1;
      end
      V2: begin
        xi_d = v2_q.x;
        yi_d = v2_q.y;
      end
      V3: begin
        xi_d = v3_q.x;
        yi_d = v3_q.y;
      end
      DONE:    done_d = 1'b1;
      default: ;
    endcase

    cmd_ready_d = (state_d == IDLE) && !busy;

    if (state_d != state) timer_d = '0;
    else if (timer == '1) timer_d = timer;
    else                  timer_d = timer + TIMER_W'(1);
  end

  tri_bitmap u_bitmap (
    .clk       (clk),
    .reset     (reset),
    .clr       (accept_c),
    .set_en    ((state == RUN) && po),
    .set_x     (xo),
    .set_y     (yo),
    .rd_en     (rd_en),
    .rd_row    (rd_row),
    .pix_count (pix_count),
    .dup_seen  (dup_seen),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid)
  );
endmodule

// File: doc/tri_host.md
Name: tri_host

Overview:
- Driver and collector for the 8x8 triangle rasterizer protocol.
- Accepts one triangle descriptor through a valid/ready command port.
- Serialises the descriptor onto the rasterizer's three-cycle nt/xi/yi vertex load, then watches busy/po/xo/yo.
- Accumulates emitted points into a 64-bit bitmap with pixel count and row readback; sits between the test host/CPU side and the rasterizer.

Parameters:
- START_TIMEOUT, 4, cycles allowed after third vertex for busy to rise before err_timeout.
- RUN_TIMEOUT, 200, cycles allowed with busy high before err_timeout.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  descriptor valid
- cmd_ready  out  1  high only in IDLE
- cmd_x1, cmd_y1, cmd_x2, cmd_y2, cmd_x3, cmd_y3  in  3 each  vertex coordinates
- nt  out  1  new-triangle strobe to rasterizer
- xi, yi  out  3 each  vertex coordinate to rasterizer
- busy  in  1  rasterizer busy
- po  in  1  point-valid strobe
- xo, yo  in  3 each  point coordinate
- done  out  1  one-cycle pulse, triangle complete
- err_timeout  out  1  sticky; cleared on next command accept
- pix_count  out  7  distinct points captured, 0..64
- dup_seen  out  1  sticky; a point repeated within current triangle
- rd_en  in  1  bitmap row read request
- rd_row  in  3  row (y) index
- rd_data  out  8  bit i = point (x=i, y=rd_row)
- rd_valid  out  1  rd_data valid, 1 cycle after rd_en

Behaviour:
- Reset values: cmd_ready=0 during reset then 1 in IDLE; nt=0, xi=yi=0, done=0, err_timeout=0, pix_count=0, dup_seen=0, rd_data=0, rd_valid=0, bitmap all 0; state IDLE.
- All outputs registered.
- States: IDLE, V1, V2, V3, WAIT_BUSY, RUN, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready: latch all six coordinates, clear bitmap/pix_count/dup_seen/err_timeout, go V1.
  - Also requires busy=0; if busy=1, stay IDLE with cmd_ready=0.
- V1: drive nt=1, xi=x1, yi=y1 for exactly one cycle.
- V2: nt=0, xi=x2, yi=y2.
- V3: xi=x3, yi=y3.
- Vertex load is three consecutive cycles with no gaps; nt never asserted outside V1.
- WAIT_BUSY:
  - xi/yi return to 0; timer counts.
  - busy=1 goes RUN.
  - Timer reaches START_TIMEOUT: set err_timeout, go DONE.
- RUN:
  - Each cycle with po=1: bit index {yo,xo} set.
  - If the bit was already 1: dup_seen=1, pix_count unchanged; else pix_count+1.
  - busy falling (busy=0) goes DONE; a po in that same cycle is still captured.
  - Timer reaching RUN_TIMEOUT sets err_timeout, goes DONE.
- po outside RUN is ignored.
- DONE: done=1 for one cycle, go IDLE. Bitmap and pix_count hold until next accept.
- Readback:
  - Legal in any state; registered, 1-cycle latency.
  - A read during RUN returns the bitmap before the same-cycle po update.
- Timer is 8 bits, saturating, cleared on each state entry.
- pix_count is 7 bits so 64 is representable.
- Reset mid-operation: immediate return to reset values. Host side must re-reset the rasterizer too; no recovery handshake.

Decomposition:
- Package tri_pkg:
  - COORD_W=3, GRID=8, PIX_W=7
  - state enum (IDLE..DONE)
  - vertex struct {x,y}
- Sub-module tri_bitmap:
  - 64-bit accumulator, set/clear, duplicate detect, pix_count, registered row readback.
  - Instantiated once inside tri_host; FSM and timers stay in top.

Test Plan:
- Vertices (0,0),(2,0),(0,2), model rasterizer emits 6 points -> nt high 1 cycle with xi/yi=0/0, then 2/0, then 0/2; done pulse; pix_count=6; rows 0/1/2 read 0x07/0x03/0x01, row 3 reads 0x00.
- Degenerate (3,3),(3,3),(3,3), one point (3,3) -> pix_count=1; row 3 = 0x08; dup_seen=0.
- Model emits point (5,4) twice -> pix_count=1, dup_seen=1, row 4 = 0x20.
- Model never raises busy -> err_timeout=1 exactly START_TIMEOUT cycles after V3; done pulses; next command clears err_timeout.
- cmd_valid held high while busy=1 in IDLE -> cmd_ready=0, no nt; accept occurs the cycle after busy falls.
- reset asserted during RUN after 3 points -> all outputs 0 same cycle (async); bitmap cleared; po ignored until a new command.
